// File: rtl/codec_stream_bridge_if.sv
// Handshake and sample bundle between the audio codec, the bridge and the effect chain.
// The bridge sits on the master side; the codec/chain environment sits on the slave side.
interface codec_stream_bridge_if #(
    parameter int DATA_W = 32
) ();
    logic                     audio_in_available;
    logic                     read_audio_in;
    logic signed [DATA_W-1:0] audio_in_L;
    logic signed [DATA_W-1:0] audio_in_R;
    logic                     audio_out_allowed;
    logic                     write_audio_out;
    logic signed [DATA_W-1:0] audio_out_L;
    logic signed [DATA_W-1:0] audio_out_R;
    logic                     proc_tick;
    logic signed [DATA_W-1:0] proc_in_L;
    logic signed [DATA_W-1:0] proc_in_R;
    logic signed [DATA_W-1:0] proc_out_L;
    logic signed [DATA_W-1:0] proc_out_R;

    modport master (
        input  audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
               proc_out_L, proc_out_R,
        output read_audio_in, write_audio_out, audio_out_L, audio_out_R,
               proc_tick, proc_in_L, proc_in_R
    );

    modport slave (
        output audio_in_available, audio_in_L, audio_in_R, audio_out_allowed,
               proc_out_L, proc_out_R,
        input  read_audio_in, write_audio_out, audio_out_L, audio_out_R,
               proc_tick, proc_in_L, proc_in_R
    );
endinterface

// File: rtl/codec_stream_bridge.sv
// Elastic stereo buffering: codec input FIFO -> effect chain (fixed latency) -> output FIFO -> codec.
// Output FIFO space is reserved at issue time, so a chain result is never dropped on capture.
module codec_stream_bridge #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter int PROC_LATENCY = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    codec_stream_bridge_if.master bus,
    input  logic                  flag_clr,
    output logic                  overrun_flag,
    output logic                  underrun_flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef logic signed [DATA_W-1:0] sample_t;

    sample_t in_mem_l  [DEPTH];
    sample_t in_mem_r  [DEPTH];
    sample_t out_mem_l [DEPTH];
    sample_t out_mem_r [DEPTH];

    logic [PTR_W-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
    logic [CNT_W-1:0] in_count, out_count;
    logic             rd_q, wr_q, wrote_once;
    logic [PROC_LATENCY:0] vld_p;
    sample_t          proc_in_l_p0, proc_in_r_p0;
    sample_t          audio_out_l_q, audio_out_r_q;

    logic             in_full, in_empty, out_empty;
    logic             in_push, in_pop, out_push, out_pop;
    logic             blocked, inflight;
    logic [CNT_W:0]   reserved;
    logic             overrun_set, underrun_set;

    always_comb begin
        in_full      = (in_count == DEPTH_C);
        in_empty     = (in_count == '0);
        out_empty    = (out_count == '0);
        in_push      = bus.audio_in_available && !in_full && !rd_q;
        blocked      = |vld_p[PROC_LATENCY-1:0];
        inflight     = |vld_p;
        reserved     = {1'b0, out_count} + {{CNT_W{1'b0}}, inflight};
        in_pop       = !in_empty && (reserved < {1'b0, DEPTH_C}) && !blocked;
        out_push     = vld_p[PROC_LATENCY];
        out_pop      = bus.audio_out_allowed && !out_empty && !wr_q;
        overrun_set  = bus.audio_in_available && in_full;
        underrun_set = bus.audio_out_allowed && out_empty && wrote_once;
    end

    // FIFO storage: data only, no reset
    always_ff @(posedge CLOCK_50) begin
        if (in_push) begin
            in_mem_l[in_wr_ptr] <= bus.audio_in_L;
            in_mem_r[in_wr_ptr] <= bus.audio_in_R;
        end
        if (out_push) begin
            out_mem_l[out_wr_ptr] <= bus.proc_out_L;
            out_mem_r[out_wr_ptr] <= bus.proc_out_R;
        end
    end

    // Input side: codec read pulse and input FIFO bookkeeping
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_q      <= 1'b0;
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            rd_q <= in_push;
            if (in_push) in_wr_ptr <= in_wr_ptr + PTR_W'(1);
            if (in_pop)  in_rd_ptr <= in_rd_ptr + PTR_W'(1);
            unique case ({in_push, in_pop})
                2'b10:   in_count <= in_count + CNT_W'(1);
                2'b01:   in_count <= in_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Chain issue (p0) and capture after PROC_LATENCY further cycles
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vld_p        <= '0;
            proc_in_l_p0 <= '0;
            proc_in_r_p0 <= '0;
        end else begin
            vld_p <= {vld_p[PROC_LATENCY-1:0], in_pop};
            if (in_pop) begin
                proc_in_l_p0 <= in_mem_l[in_rd_ptr];
                proc_in_r_p0 <= in_mem_r[in_rd_ptr];
            end
        end
    end

    // Output side: codec write pulse and output FIFO bookkeeping
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_q          <= 1'b0;
            wrote_once    <= 1'b0;
            out_wr_ptr    <= '0;
            out_rd_ptr    <= '0;
            out_count     <= '0;
            audio_out_l_q <= '0;
            audio_out_r_q <= '0;
        end else begin
            wr_q <= out_pop;
            if (out_pop) begin
                wrote_once    <= 1'b1;
                out_rd_ptr    <= out_rd_ptr + PTR_W'(1);
                audio_out_l_q <= out_mem_l[out_rd_ptr];
                audio_out_r_q <= out_mem_r[out_rd_ptr];
            end
            if (out_push) out_wr_ptr <= out_wr_ptr + PTR_W'(1);
            unique case ({out_push, out_pop})
                2'b10:   out_count <= out_count + CNT_W'(1);
                2'b01:   out_count <= out_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky flags: a new event outranks a simultaneous clear
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            overrun_flag  <= 1'b0;
            underrun_flag <= 1'b0;
        end else begin
            if (overrun_set)       overrun_flag <= 1'b1;
            else if (flag_clr)     overrun_flag <= 1'b0;
            if (underrun_set)      underrun_flag <= 1'b1;
            else if (flag_clr)     underrun_flag <= 1'b0;
        end
    end

    assign bus.read_audio_in   = rd_q;
    assign bus.write_audio_out = wr_q;
    assign bus.audio_out_L     = audio_out_l_q;
    assign bus.audio_out_R     = audio_out_r_q;
    assign bus.proc_tick       = vld_p[0];
    assign bus.proc_in_L       = proc_in_l_p0;
    assign bus.proc_in_R       = proc_in_r_p0;

endmodule

// File: tb/tb_codec_stream_bridge.sv
// Bench for codec_stream_bridge: fixed-latency chain model, FIFO-order scoreboard, flag and reset scenarios.
module tb_codec_stream_bridge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PL     = 2;
    localparam logic [DATA_W-1:0] POISON = 32'hDEAD_BEEF;

    logic clk      = 1'b0;
    logic resetn   = 1'b0;
    logic flag_clr = 1'b0;
    logic overrun_flag, underrun_flag;

    int checks = 0;
    int errors = 0;

    codec_stream_bridge_if #(.DATA_W(DATA_W)) bus ();

    codec_stream_bridge #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .PROC_LATENCY(PL)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .bus(bus),
        .flag_clr(flag_clr),
        .overrun_flag(overrun_flag),
        .underrun_flag(underrun_flag)
    );

    always #10 clk = ~clk;

    // Effect chain: result valid PL cycles after the tick cycle, garbage otherwise
    logic              chain_v [PL];
    logic [DATA_W-1:0] chain_l [PL];
    logic [DATA_W-1:0] chain_r [PL];

    always @(posedge clk) begin
        chain_v[0] <= bus.proc_tick;
        chain_l[0] <= bus.proc_in_L;
        chain_r[0] <= bus.proc_in_R;
        for (int i = 1; i < PL; i++) begin
            chain_v[i] <= chain_v[i-1];
            chain_l[i] <= chain_l[i-1];
            chain_r[i] <= chain_r[i-1];
        end
    end

    assign bus.proc_out_L = chain_v[PL-1] ? chain_l[PL-1] : POISON;
    assign bus.proc_out_R = chain_v[PL-1] ? chain_r[PL-1] : ~POISON;

    // Monitor: every sample read must reappear once, in order, at the output
    logic [2*DATA_W-1:0] exp_q[$];
    logic [2*DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0]   in_l_s, in_r_s;
    logic                prev_rd = 1'b0;
    int rd_cnt = 0, wr_cnt = 0, tick_cnt = 0, consec_err = 0;
    int cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        in_l_s <= bus.audio_in_L;
        in_r_s <= bus.audio_in_R;
    end

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            got_q.delete();
            prev_rd <= 1'b0;
        end else begin
            if (bus.read_audio_in) begin
                exp_q.push_back({in_l_s, in_r_s});
                rd_cnt      <= rd_cnt + 1;
                last_rd_cyc <= cyc;
                if (prev_rd) consec_err <= consec_err + 1;
            end
            if (bus.write_audio_out) begin
                got_q.push_back({bus.audio_out_L, bus.audio_out_R});
                wr_cnt      <= wr_cnt + 1;
                last_wr_cyc <= cyc;
            end
            if (bus.proc_tick) tick_cnt <= tick_cnt + 1;
            prev_rd <= bus.read_audio_in;
        end
    end

    task automatic step(input int n, input bit rnd);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (rnd) begin
                bus.audio_in_L = $urandom;
                bus.audio_in_R = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        bus.audio_in_available = 1'b0;
        bus.audio_out_allowed  = 1'b0;
        flag_clr               = 1'b0;
        step(1, 0);
        resetn = 1'b0;
        step(2, 0);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0]          ctl;
        logic [4*DATA_W-1:0] dat;
        step(1, 0);
        resetn = 1'b0;
        #1;
        ctl = {bus.read_audio_in, bus.write_audio_out, bus.proc_tick, overrun_flag, underrun_flag};
        dat = {bus.proc_in_L, bus.proc_in_R, bus.audio_out_L, bus.audio_out_R};
        checks++;
        if (ctl !== 5'b0) begin errors++; $display("FAIL reset_ctl got=%b want=0", ctl); end
        checks++;
        if (dat !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", dat); end
        step(2, 0);
        resetn = 1'b1;
        step(3, 0);
        ctl = {bus.read_audio_in, bus.write_audio_out, bus.proc_tick, overrun_flag, underrun_flag};
        dat = {bus.proc_in_L, bus.proc_in_R, bus.audio_out_L, bus.audio_out_R};
        checks++;
        if (ctl !== 5'b0) begin errors++; $display("FAIL idle_ctl got=%b want=0", ctl); end
        checks++;
        if (dat !== '0) begin errors++; $display("FAIL idle_data got=%h want=0", dat); end
    endtask

    task automatic test_single();
        int rd_at, lat;
        bit seen;
        do_reset();
        bus.audio_out_allowed  = 1'b1;
        bus.audio_in_L         = 32'h0012_3456;
        bus.audio_in_R         = 32'hFFED_CBAA;
        bus.audio_in_available = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0);
            seen = bus.read_audio_in;
        end
        bus.audio_in_available = 1'b0;
        rd_at = last_rd_cyc;
        checks++;
        if (!seen) begin errors++; $display("FAIL single_read got=none want=read"); end
        step(1, 0);
        checks++;
        if (underrun_flag !== 1'b0) begin errors++; $display("FAIL underrun_before_first_write got=%b want=0", underrun_flag); end
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1, 0);
            seen = (got_q.size() != 0);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_write got=none want=write");
        end else begin
            lat = last_wr_cyc - rd_at;
            checks++;
            if (lat != 3 + PL) begin errors++; $display("FAIL single_latency got=%0d want=%0d", lat, 3 + PL); end
            checks++;
            if (got_q[0] !== {32'h0012_3456, 32'hFFED_CBAA})
                begin errors++; $display("FAIL single_data got=%h want=%h", got_q[0], {32'h0012_3456, 32'hFFED_CBAA}); end
        end
        step(4, 0);
        checks++;
        if (overrun_flag !== 1'b0) begin errors++; $display("FAIL single_overrun got=%b want=0", overrun_flag); end
        checks++;
        if (underrun_flag !== 1'b1) begin errors++; $display("FAIL single_underrun got=%b want=1", underrun_flag); end
    endtask

    task automatic test_burst();
        int rd0, tk0, tk1, ce0;
        do_reset();
        rd0 = rd_cnt; tk0 = tick_cnt; ce0 = consec_err;
        bus.audio_out_allowed  = 1'b0;
        bus.audio_in_available = 1'b1;
        step(70, 1);
        tk1 = tick_cnt;
        step(30, 1);
        bus.audio_in_available = 1'b0;
        step(1, 0);
        checks++;
        if (rd_cnt - rd0 != 2 * DEPTH) begin errors++; $display("FAIL burst_reads got=%0d want=%0d", rd_cnt - rd0, 2 * DEPTH); end
        checks++;
        if (tick_cnt - tk0 != DEPTH) begin errors++; $display("FAIL burst_ticks got=%0d want=%0d", tick_cnt - tk0, DEPTH); end
        checks++;
        if (tick_cnt != tk1) begin errors++; $display("FAIL burst_tick_when_full got=%0d want=0", tick_cnt - tk1); end
        checks++;
        if (overrun_flag !== 1'b1) begin errors++; $display("FAIL burst_overrun got=%b want=1", overrun_flag); end
        checks++;
        if (consec_err != ce0) begin errors++; $display("FAIL burst_consec_reads got=%0d want=0", consec_err - ce0); end
    endtask

    task automatic test_drain();
        int wr0;
        wr0 = wr_cnt;
        bus.audio_in_available = 1'b0;
        bus.audio_out_allowed  = 1'b1;
        for (int i = 0; i < 200 && got_q.size() < 2 * DEPTH; i++) step(1, 0);
        step(20, 0);
        checks++;
        if (wr_cnt - wr0 != 2 * DEPTH) begin errors++; $display("FAIL drain_writes got=%0d want=%0d", wr_cnt - wr0, 2 * DEPTH); end
        for (int i = 0; i < 2 * DEPTH && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (underrun_flag !== 1'b1) begin errors++; $display("FAIL drain_underrun got=%b want=1", underrun_flag); end
    endtask

    task automatic test_flag_clr();
        bus.audio_out_allowed  = 1'b0;
        bus.audio_in_available = 1'b1;
        step(60, 1);
        bus.audio_in_available = 1'b0;
        step(1, 0);
        flag_clr = 1'b1;
        step(1, 0);
        flag_clr = 1'b0;
        checks++;
        if ({overrun_flag, underrun_flag} !== 2'b00)
            begin errors++; $display("FAIL flag_clr_idle got=%b want=00", {overrun_flag, underrun_flag}); end
        bus.audio_in_available = 1'b1;
        flag_clr = 1'b1;
        step(1, 0);
        flag_clr = 1'b0;
        bus.audio_in_available = 1'b0;
        checks++;
        if (overrun_flag !== 1'b1) begin errors++; $display("FAIL flag_clr_vs_overrun got=%b want=1", overrun_flag); end
        checks++;
        if (underrun_flag !== 1'b0) begin errors++; $display("FAIL flag_clr_underrun got=%b want=0", underrun_flag); end
    endtask

    task automatic test_random();
        int ce0, n;
        do_reset();
        ce0 = consec_err;
        for (int i = 0; i < 500; i++) begin
            step(1, 1);
            bus.audio_in_available = ($urandom_range(0, 9) < 6);
            bus.audio_out_allowed  = ($urandom_range(0, 9) < 5);
        end
        bus.audio_in_available = 1'b0;
        bus.audio_out_allowed  = 1'b1;
        step(5, 0);
        for (int i = 0; i < 400 && got_q.size() != exp_q.size(); i++) step(1, 0);
        step(10, 0);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (consec_err != ce0) begin errors++; $display("FAIL random_consec_reads got=%0d want=0", consec_err - ce0); end
    endtask

    task automatic test_reset_midstream();
        logic [4:0]          ctl;
        logic [4*DATA_W-1:0] dat;
        int  reads;
        bit  seen;
        do_reset();
        bus.audio_out_allowed  = 1'b1;
        bus.audio_in_available = 1'b1;
        step(14, 1);
        bus.audio_out_allowed = 1'b0;
        reads = 0;
        for (int i = 0; i < 20 && reads < 3; i++) begin
            step(1, 1);
            if (bus.read_audio_in) reads++;
        end
        bus.audio_in_available = 1'b0;
        step(1, 0);
        resetn = 1'b0;
        #1;
        ctl = {bus.read_audio_in, bus.write_audio_out, bus.proc_tick, overrun_flag, underrun_flag};
        dat = {bus.proc_in_L, bus.proc_in_R, bus.audio_out_L, bus.audio_out_R};
        checks++;
        if (ctl !== 5'b0) begin errors++; $display("FAIL midreset_ctl got=%b want=0", ctl); end
        checks++;
        if (dat !== '0) begin errors++; $display("FAIL midreset_data got=%h want=0", dat); end
        step(2, 0);
        resetn = 1'b1;
        bus.audio_in_L = 32'hA5A5_0001;
        bus.audio_in_R = 32'h5A5A_0002;
        bus.audio_in_available = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 0);
            seen = bus.read_audio_in;
        end
        bus.audio_in_available = 1'b0;
        bus.audio_out_allowed  = 1'b1;
        for (int i = 0; i < 30 && got_q.size() == 0; i++) step(1, 0);
        step(10, 0);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midreset_writes got=%0d want=1", got_q.size());
        end
        if (got_q.size() != 0) begin
            checks++;
            if (got_q[0] !== {32'hA5A5_0001, 32'h5A5A_0002})
                begin errors++; $display("FAIL midreset_first got=%h want=%h", got_q[0], {32'hA5A5_0001, 32'h5A5A_0002}); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.audio_in_available = 1'b0;
        bus.audio_out_allowed  = 1'b0;
        bus.audio_in_L         = '0;
        bus.audio_in_R         = '0;
        test_reset();
        test_single();
        test_burst();
        test_drain();
        test_flag_clr();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
